// File: rtl/dco_pkg.sv
// ============================================================================
// Module      : dco_pkg
// Description : Shared DCO period/code constants, period-to-code decoder and
//               period-meter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dco_pkg;

    // DCO period values N (half-period is N+1 clk cycles) and their codes
    localparam logic [15:0] c_N_CODE7 = 16'd10;
    localparam logic [15:0] c_N_CODE6 = 16'd9;
    localparam logic [15:0] c_N_CODE5 = 16'd8;
    localparam logic [15:0] c_N_CODE4 = 16'd7;
    localparam logic [15:0] c_N_CODE3 = 16'd6;
    localparam logic [15:0] c_N_CODE2 = 16'd5;
    localparam logic [15:0] c_N_CODE1 = 16'd4;
    localparam logic [15:0] c_N_CODE0 = 16'd3;
    localparam logic [15:0] c_N_ZERO  = 16'd50;

    localparam logic [7:0] c_CODE7 = 8'b1000_0000;
    localparam logic [7:0] c_CODE6 = 8'b0100_0000;
    localparam logic [7:0] c_CODE5 = 8'b0010_0000;
    localparam logic [7:0] c_CODE4 = 8'b0001_0000;
    localparam logic [7:0] c_CODE3 = 8'b0000_1000;
    localparam logic [7:0] c_CODE2 = 8'b0000_0100;
    localparam logic [7:0] c_CODE1 = 8'b0000_0010;
    localparam logic [7:0] c_CODE0 = 8'b0000_0001;
    localparam logic [7:0] c_CODE_ZERO = 8'b0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        TRACK = 2'd2
    } meter_state_t;

    // Returns {err, code}; unmapped periods give err=1 with a zero code
    function automatic logic [8:0] period_to_code(input logic [15:0] n);
        logic [8:0] result;
        result = {1'b1, 8'h00};
        case (n)
            c_N_CODE7: result = {1'b0, c_CODE7};
            c_N_CODE6: result = {1'b0, c_CODE6};
            c_N_CODE5: result = {1'b0, c_CODE5};
            c_N_CODE4: result = {1'b0, c_CODE4};
            c_N_CODE3: result = {1'b0, c_CODE3};
            c_N_CODE2: result = {1'b0, c_CODE2};
            c_N_CODE1: result = {1'b0, c_CODE1};
            c_N_CODE0: result = {1'b0, c_CODE0};
            c_N_ZERO:  result = {1'b0, c_CODE_ZERO};
            default:   result = {1'b1, 8'h00};
        endcase
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dco_sync_edge.sv
// ============================================================================
// Module      : dco_sync_edge
// Description : Two-flop synchroniser for sig_in followed by a registered
//               both-edge detector (edge_det is a one-cycle pulse).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dco_sync_edge (
    input  logic clk,
    input  logic resetn,
    input  logic sig_in,
    output logic edge_det
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_edge;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_edge  <= 1'b0;
        end else begin
            r_sync1 <= sig_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_edge  <= r_sync2 ^ r_prev;
        end
    end

    assign edge_det = r_edge;

endmodule

`default_nettype wire

// File: rtl/dco_period_meter.sv
// ============================================================================
// Module      : dco_period_meter
// Description : Measures the edge-to-edge interval of a DCO waveform, decodes
//               it to the DCO code, tracks lock/timeout, valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dco_period_meter
    import dco_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 200
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ena,
    input  logic             sig_in,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CNT_W-1:0] half_period,
    output logic [7:0]       code_out,
    output logic             code_err,
    output logic             locked,
    output logic             timeout,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] c_TIMEOUT    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] c_ONE        = CNT_W'(1);
    localparam logic [3:0]       c_LOCK       = 4'(LOCK_COUNT);

    logic             w_edge;
    meter_state_t     r_state,   w_state_nxt;
    logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;
    logic [CNT_W-1:0] r_last_l,  w_last_l_nxt;
    logic [3:0]       r_match,   w_match_nxt;
    logic             r_valid,   w_valid_nxt;
    logic [CNT_W-1:0] r_half,    w_half_nxt;
    logic [7:0]       r_code,    w_code_nxt;
    logic             r_err,     w_err_nxt;
    logic             r_locked,  w_locked_nxt;
    logic             r_timeout, w_timeout_nxt;
    logic             r_overrun, w_overrun_nxt;
    logic             w_meas;
    logic [CNT_W-1:0] w_l;
    logic [CNT_W-1:0] w_n;
    logic [8:0]       w_dec;

    dco_sync_edge u_sync_edge (
        .clk      (clk),
        .resetn   (resetn),
        .sig_in   (sig_in),
        .edge_det (w_edge)
    );

    assign w_l   = (r_cnt == c_CNT_MAX) ? c_CNT_MAX : r_cnt + c_ONE;
    assign w_n   = w_l - c_ONE;
    assign w_dec = period_to_code(16'(w_n));

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = (r_cnt == c_TIMEOUT) ? r_cnt : r_cnt + c_ONE;
        w_last_l_nxt  = r_last_l;
        w_match_nxt   = r_match;
        w_locked_nxt  = r_locked;
        w_timeout_nxt = r_timeout;
        w_meas        = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt_nxt = r_cnt;
                if (w_edge) begin
                    w_state_nxt   = ARMED;
                    w_cnt_nxt     = '0;
                    w_timeout_nxt = 1'b0;
                end
            end
            ARMED, TRACK: begin
                if (w_edge) begin
                    w_state_nxt   = TRACK;
                    w_cnt_nxt     = '0;
                    w_timeout_nxt = 1'b0;
                    w_meas        = 1'b1;
                    w_last_l_nxt  = w_l;
                    if (r_state == TRACK && w_l == r_last_l)
                        w_match_nxt = (r_match >= c_LOCK) ? c_LOCK : r_match + 4'd1;
                    else
                        w_match_nxt = 4'd1;
                    w_locked_nxt = (w_match_nxt == c_LOCK);
                end else if (r_cnt == c_TIMEOUT_M1) begin
                    // Counter reaches TIMEOUT on this edge: input is dead
                    w_state_nxt   = IDLE;
                    w_timeout_nxt = 1'b1;
                    w_locked_nxt  = 1'b0;
                    w_match_nxt   = 4'd0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_valid_nxt   = r_valid;
        w_overrun_nxt = 1'b0;
        w_half_nxt    = r_half;
        w_code_nxt    = r_code;
        w_err_nxt     = r_err;
        if (w_meas) begin
            w_valid_nxt   = 1'b1;
            w_overrun_nxt = r_valid && !meas_ready;
            w_half_nxt    = w_l;
            w_code_nxt    = w_dec[7:0];
            w_err_nxt     = w_dec[8];
        end else if (r_valid && meas_ready) begin
            w_valid_nxt = 1'b0;
        end

        if (!ena) begin
            w_state_nxt   = IDLE;
            w_cnt_nxt     = '0;
            w_match_nxt   = 4'd0;
            w_locked_nxt  = 1'b0;
            w_timeout_nxt = 1'b0;
            w_valid_nxt   = 1'b0;
            w_overrun_nxt = 1'b0;
            w_half_nxt    = '0;
            w_code_nxt    = 8'h00;
            w_err_nxt     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_last_l  <= '0;
            r_match   <= 4'd0;
            r_valid   <= 1'b0;
            r_half    <= '0;
            r_code    <= 8'h00;
            r_err     <= 1'b0;
            r_locked  <= 1'b0;
            r_timeout <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_last_l  <= w_last_l_nxt;
            r_match   <= w_match_nxt;
            r_valid   <= w_valid_nxt;
            r_half    <= w_half_nxt;
            r_code    <= w_code_nxt;
            r_err     <= w_err_nxt;
            r_locked  <= w_locked_nxt;
            r_timeout <= w_timeout_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    assign meas_valid  = r_valid;
    assign half_period = r_half;
    assign code_out    = r_code;
    assign code_err    = r_err;
    assign locked      = r_locked;
    assign timeout     = r_timeout;
    assign overrun     = r_overrun;

endmodule

`default_nettype wire
